dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data `memory`. It sits between the datapath MEM stage (port 0) and a secondary master such as a loader or debug port (port 1). It accepts one read or write at a time under a req/ack handshake with round-robin fairness, drives `MemRead`/`MemWrite`/`Address`/`WD`, and captures `RD` back into a per-port read-data register.

## Interface
- `WIDTH`, 32, data and address width in bits
- `DEPTH`, 16, number of memory words; valid addresses are 0..DEPTH-1
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0`, `req1`  in  1  request from port 0 / port 1
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  WIDTH  word address
- `wdata0`, `wdata1`  in  WIDTH  write data
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `err0`, `err1`  out  1  valid only with ack; set when the address is out of range
- `rdata0`, `rdata1`  out  WIDTH  read result; valid with ack on a read, held until the next read on that port
- `MemRead`  out  1  memory read enable
- `MemWrite`  out  1  memory write enable
- `Address`  out  WIDTH  memory address
- `WD`  out  WIDTH  memory write data
- `RD`  in  WIDTH  memory read data; valid the cycle after `MemRead`

## Operation
- FSM states: IDLE, WRITE, READ, CAPTURE, ACK.
- **IDLE:** sample `req0`/`req1`.
  - Only one request: grant it.
  - Both requests: grant the port not in `last`, then set `last` to the granted port.
  - Latch the granted `we`, `addr`, `wdata` and the port id.
  - Address ≥ DEPTH: go to ACK with `err` set; no memory enable is asserted.
  - Otherwise go to WRITE if `we`=1, else READ.
- **WRITE:** `MemWrite`=1; `Address`/`WD` = latched values. Next state ACK.
- **READ:** `MemRead`=1; `Address` = latched addr. Next state CAPTURE.
- **CAPTURE:** enables low; register `RD` into the granted port's `rdata`. Next state ACK.
- **ACK:** pulse the granted port's `ack` (and `err` if flagged). Next state IDLE.
- `MemRead` and `MemWrite` are never asserted together. Both are 0 in IDLE, CAPTURE and ACK.
- `Address`/`WD` are 0 whenever no enable is asserted.
- The non-granted port's request is held pending and is not lost. The requester keeps `req` and its fields stable until ack.
- Requester rule: a port drops `req` at the edge that samples its `ack`. A `req` still high in the next IDLE cycle is treated as a new transaction.
- Request fields are captured in IDLE only. Changes after the grant have no effect on the transaction in flight.

## Timing
- Reset:
  - State = IDLE; `last` = 1, so port 0 wins the first tie.
  - All `ack`/`err` = 0, `rdata0`/`rdata1` = 0.
  - `MemRead`, `MemWrite` = 0; `Address`, `WD` = 0.
- Write, request seen in IDLE at cycle 0: `MemWrite` in cycle 1, `ack` in cycle 2, IDLE in cycle 3. Three cycles per write.
- Read, request at cycle 0: `MemRead` in cycle 1, `RD` sampled at the end of cycle 2, `ack` and valid `rdata` in cycle 3. Four cycles per read.
- Out-of-range access: `ack`+`err` in cycle 1. Two cycles total.
- Back-to-back: a pending port is granted in the IDLE cycle directly after the other port's ACK. Each port therefore gets service at most every two transactions.
- `rst` in any state aborts the transaction at that edge: no ack, no further memory enable, and `rdata` is cleared.
- Enables and all outputs are registered; there are no combinational paths from `req` to the memory side.

## Test plan
- **Reset:** assert `rst` mid-READ → next cycle `MemRead`=0, `ack0`=`ack1`=0, `rdata0`=0, state IDLE, and no ack afterwards.
- **Single write then read, port 0:** write 0xDEADBEEF to addr 5 → `MemWrite`=1 with `Address`=5, `WD`=0xDEADBEEF in cycle 1, `ack0` in cycle 2. Then read addr 5 → `ack0` in cycle 3 with `rdata0`=0xDEADBEEF.
- **Simultaneous requests after reset:** port 0 write addr 1 = 0x11 and port 1 write addr 2 = 0x22 → port 0 served first (`ack0`), port 1 served next (`ack1` three cycles later). Both addresses read back correctly.
- **Fairness:** hold `req0` and `req1` continuously with reads → acks alternate 0,1,0,1 for at least 6 transactions, and neither port is starved.
- **Out of range:** port 1 reads addr 16 with DEPTH=16 → `MemRead` never asserted, `ack1`=`err1`=1 one cycle after the grant, `rdata1` unchanged.
- **Field change after grant:** port 0 changes `addr0` from 3 to 7 one cycle after the grant → the access uses `Address`=3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Purpose: round-robin arbiter/sequencer giving two requesters turns on a single-port data memory.
// Latency: write 3 cycles, read 4 cycles, out-of-range 2 cycles from the IDLE cycle that sees req to IDLE again.
// Backpressure: one transaction in flight; the losing port's req stays pending until it is granted and acked.
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             ack0,
    output logic             ack1,
    output logic             err0,
    output logic             err1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] WD,
    input  logic [WIDTH-1:0] RD
);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    typedef enum logic [2:0] {IDLE, WRITE, READ, CAPTURE, ACK} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             port_q, port_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             gnt;

    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [WIDTH-1:0] address_q, address_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic             ack0_q, ack0_d, ack1_q, ack1_d;
    logic             err0_q, err0_d, err1_q, err1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // State register; reset aborts whatever transaction is in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Arbitration, request capture, next state, and next values of every registered output.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        port_d   = port_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        gnt      = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time gets the grant.
                    gnt     = (req0 && req1) ? ~last_q : req1;
                    port_d  = gnt;
                    last_d  = gnt;
                    we_d    = gnt ? we1    : we0;
                    addr_d  = gnt ? addr1  : addr0;
                    wdata_d = gnt ? wdata1 : wdata0;
                    err_d   = (addr_d >= DEPTH_W);
                    if (err_d)     state_d = ACK;
                    else if (we_d) state_d = WRITE;
                    else           state_d = READ;
                end
            end
            WRITE:   state_d = ACK;
            READ:    state_d = CAPTURE;
            CAPTURE: begin
                state_d = ACK;
                // RD is valid the cycle after MemRead, i.e. now.
                if (port_q) rdata1_d = RD;
                else        rdata0_d = RD;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave the block registered.
        mem_write_d = (state_d == WRITE);
        mem_read_d  = (state_d == READ);
        address_d   = (mem_write_d || mem_read_d) ? addr_d : '0;
        wd_d        = mem_write_d ? wdata_d : '0;
        ack0_d      = (state_d == ACK) && !port_d;
        ack1_d      = (state_d == ACK) &&  port_d;
        err0_d      = ack0_d && err_d;
        err1_d      = ack1_d && err_d;
    end

    // Latched transaction fields, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            address_q   <= '0;
            wd_q        <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            last_q      <= last_d;
            port_q      <= port_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            address_q   <= address_d;
            wd_q        <= wd_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign Address  = address_q;
    assign WD       = wd_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign err0     = err0_q;
    assign err1     = err1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter with a behavioural single-port memory.
// Latency: checks write/read/out-of-range ack timing against cycle counts from the request cycle.
// Backpressure: requesters hold req and fields until ack, then drop req on the edge that samples ack.
module tb_dmem_arbiter;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, we0, we1;
    logic [WIDTH-1:0] addr0, addr1, wdata0, wdata1;
    logic             ack0, ack1, err0, err1;
    logic [WIDTH-1:0] rdata0, rdata1;
    logic             MemRead, MemWrite;
    logic [WIDTH-1:0] Address, WD, RD;

    dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .WD(WD),
        .RD(RD)
    );

    always #5 clk = ~clk;

    // Single-port memory: write on MemWrite, registered read data one cycle after MemRead.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (MemWrite === 1'b1) mem[Address[3:0]] <= WD;
        if (MemRead === 1'b1)  RD <= mem[Address[3:0]];
    end

    typedef struct {
        logic             err;
        logic [WIDTH-1:0] rdata;
    } exp_t;

    exp_t             sb0[$];
    exp_t             sb1[$];
    exp_t             e_mon;
    logic [WIDTH-1:0] model [0:DEPTH-1];
    logic [WIDTH-1:0] exp_rd [0:1];
    int               n_cmp = 0;
    int               n_fail = 0;
    int               n_memrd = 0;

    // Monitor: pop expected ack contents per port and check memory-side invariants.
    always @(negedge clk) begin
        if (MemRead === 1'b1) n_memrd++;
        if (MemRead === 1'b1 || MemWrite === 1'b1) begin
            n_cmp++;
            if ((MemRead & MemWrite) !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_exclusive: MemRead=%b MemWrite=%b, required not both", MemRead, MemWrite);
            end
        end else if (MemRead === 1'b0 && MemWrite === 1'b0) begin
            n_cmp++;
            if (Address !== '0 || WD !== '0) begin
                n_fail++;
                $display("FAIL idle_bus: Address=%h WD=%h, required 0 with no enable", Address, WD);
            end
        end
        if (ack0 === 1'b1) begin
            n_cmp++;
            if (sb0.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack0: ack0=1, required no ack");
            end else begin
                e_mon = sb0.pop_front();
                if (err0 !== e_mon.err) begin
                    n_fail++;
                    $display("FAIL ack0_err: err0=%b, required %b", err0, e_mon.err);
                end
                n_cmp++;
                if (rdata0 !== e_mon.rdata) begin
                    n_fail++;
                    $display("FAIL ack0_rdata: rdata0=%h, required %h", rdata0, e_mon.rdata);
                end
            end
        end
        if (ack1 === 1'b1) begin
            n_cmp++;
            if (sb1.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack1: ack1=1, required no ack");
            end else begin
                e_mon = sb1.pop_front();
                if (err1 !== e_mon.err) begin
                    n_fail++;
                    $display("FAIL ack1_err: err1=%b, required %b", err1, e_mon.err);
                end
                n_cmp++;
                if (rdata1 !== e_mon.rdata) begin
                    n_fail++;
                    $display("FAIL ack1_rdata: rdata1=%h, required %h", rdata1, e_mon.rdata);
                end
            end
        end
        if ((ack0 !== 1'b1 && err0 === 1'b1) || (ack1 !== 1'b1 && err1 === 1'b1)) begin
            n_fail++;
            $display("FAIL err_without_ack: err0=%b err1=%b, required 0 without ack", err0, err1);
        end
    end

    // Driver: issue one transaction, push its expectation, and report ack latency and cycle-1 bus values.
    task automatic drive_txn(input bit port, input bit we, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] d, output int lat,
                             output logic mr1, output logic mw1,
                             output logic [WIDTH-1:0] ad1, output logic [WIDTH-1:0] wd1);
        exp_t e;
        @(posedge clk); #1;
        if (port) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else      begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        e.err = (a >= WIDTH'(DEPTH));
        if (!e.err && we)  model[a[3:0]] = d;
        if (!e.err && !we) exp_rd[port] = model[a[3:0]];
        e.rdata = exp_rd[port];
        if (port) sb1.push_back(e);
        else      sb0.push_back(e);
        lat = -1; mr1 = 1'bx; mw1 = 1'bx; ad1 = 'x; wd1 = 'x;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 1) begin mr1 = MemRead; mw1 = MemWrite; ad1 = Address; wd1 = WD; end
            if ((port ? ack1 : ack0) === 1'b1) begin lat = k; break; end
        end
        @(posedge clk); #1;
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (MemRead !== 1'b0)  begin n_fail++; $display("FAIL rst_MemRead: %b, required 0", MemRead); end
        n_cmp++; if (MemWrite !== 1'b0) begin n_fail++; $display("FAIL rst_MemWrite: %b, required 0", MemWrite); end
        n_cmp++; if (Address !== '0)    begin n_fail++; $display("FAIL rst_Address: %h, required 0", Address); end
        n_cmp++; if (WD !== '0)         begin n_fail++; $display("FAIL rst_WD: %h, required 0", WD); end
        n_cmp++; if ({ack0, ack1, err0, err1} !== 4'b0) begin
            n_fail++; $display("FAIL rst_ack_err: %b, required 0000", {ack0, ack1, err0, err1});
        end
        n_cmp++; if (rdata0 !== '0)     begin n_fail++; $display("FAIL rst_rdata0: %h, required 0", rdata0); end
        n_cmp++; if (rdata1 !== '0)     begin n_fail++; $display("FAIL rst_rdata1: %h, required 0", rdata1); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_write_read;
        int lat; logic mr, mw; logic [WIDTH-1:0] ad, wd;
        drive_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 2)            begin n_fail++; $display("FAIL wr_latency: %0d, required 2", lat); end
        n_cmp++; if (mw !== 1'b1 || mr !== 1'b0) begin
            n_fail++; $display("FAIL wr_enables: MemWrite=%b MemRead=%b, required 1/0", mw, mr);
        end
        n_cmp++; if (ad !== 32'd5)        begin n_fail++; $display("FAIL wr_Address: %h, required 5", ad); end
        n_cmp++; if (wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_WD: %h, required deadbeef", wd); end
        drive_txn(1'b0, 1'b0, 32'd5, 32'h0, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 3)            begin n_fail++; $display("FAIL rd_latency: %0d, required 3", lat); end
        n_cmp++; if (mr !== 1'b1 || mw !== 1'b0 || ad !== 32'd5) begin
            n_fail++; $display("FAIL rd_bus: MemRead=%b MemWrite=%b Address=%h, required 1/0/5", mr, mw, ad);
        end
    endtask

    task automatic test_reset_mid_read;
        int lat; logic mr, mw; logic [WIDTH-1:0] ad, wd;
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd5;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        n_cmp++; if (MemRead !== 1'b1) begin n_fail++; $display("FAIL midrd_MemRead_before: %b, required 1", MemRead); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        n_cmp++; if (MemRead !== 1'b0) begin n_fail++; $display("FAIL midrd_MemRead_after: %b, required 0", MemRead); end
        n_cmp++; if ({ack0, ack1} !== 2'b00) begin n_fail++; $display("FAIL midrd_ack: %b, required 00", {ack0, ack1}); end
        n_cmp++; if (rdata0 !== '0) begin n_fail++; $display("FAIL midrd_rdata0: %h, required 0", rdata0); end
        repeat (8) @(posedge clk);
        // Back in IDLE: a fresh write must complete with normal timing.
        drive_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 2) begin n_fail++; $display("FAIL midrd_recover_latency: %0d, required 2", lat); end
    endtask

    task automatic test_simultaneous;
        int lat0, lat1, lat; logic mr, mw, mr_b, mw_b; logic [WIDTH-1:0] ad, wd, ad_b, wd_b;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        fork
            drive_txn(1'b0, 1'b1, 32'd1, 32'h11, lat0, mr, mw, ad, wd);
            drive_txn(1'b1, 1'b1, 32'd2, 32'h22, lat1, mr_b, mw_b, ad_b, wd_b);
        join
        n_cmp++; if (lat0 != 2) begin n_fail++; $display("FAIL tie_port0_latency: %0d, required 2", lat0); end
        n_cmp++; if (lat1 != 5) begin n_fail++; $display("FAIL tie_port1_latency: %0d, required 5", lat1); end
        n_cmp++; if (ad !== 32'd1 || wd !== 32'h11) begin
            n_fail++; $display("FAIL tie_first_bus: Address=%h WD=%h, required 1/11", ad, wd);
        end
        drive_txn(1'b0, 1'b0, 32'd2, 32'h0, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL tie_readback0_latency: %0d, required 3", lat); end
        drive_txn(1'b1, 1'b0, 32'd1, 32'h0, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL tie_readback1_latency: %0d, required 3", lat); end
    endtask

    task automatic test_fairness;
        exp_t e;
        int   seen = 0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        exp_rd[0] = model[1]; exp_rd[1] = model[2];
        for (int i = 0; i < 3; i++) begin
            e.err = 1'b0; e.rdata = model[1]; sb0.push_back(e);
            e.rdata = model[2]; sb1.push_back(e);
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
        for (int k = 0; k < 60 && seen < 6; k++) begin
            @(negedge clk);
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                n_cmp++;
                if ({ack1, ack0} !== ((seen % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL fair_order[%0d]: ack1ack0=%b, required port %0d", seen, {ack1, ack0}, seen % 2);
                end
                seen++;
            end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++; if (seen != 6) begin n_fail++; $display("FAIL fair_count: %0d acks, required 6", seen); end
    endtask

    task automatic test_out_of_range;
        int lat; int rd_before; logic mr, mw; logic [WIDTH-1:0] ad, wd;
        rd_before = n_memrd;
        drive_txn(1'b1, 1'b0, 32'd16, 32'h0, lat, mr, mw, ad, wd);
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL oor_latency: %0d, required 1", lat); end
        n_cmp++; if (n_memrd != rd_before) begin
            n_fail++; $display("FAIL oor_MemRead: %0d cycles asserted, required 0", n_memrd - rd_before);
        end
    endtask

    task automatic test_field_change;
        int lat; logic mr, mw; logic [WIDTH-1:0] ad, wd;
        exp_t e;
        drive_txn(1'b0, 1'b1, 32'd7, 32'h77, lat, mr, mw, ad, wd);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'd3; wdata0 = 32'h33;
        model[3] = 32'h33;
        e.err = 1'b0; e.rdata = exp_rd[0]; sb0.push_back(e);
        @(posedge clk); #1;
        addr0 = 32'd7; wdata0 = 32'h99;
        @(negedge clk);
        n_cmp++; if (MemWrite !== 1'b1 || Address !== 32'd3 || WD !== 32'h33) begin
            n_fail++; $display("FAIL chg_bus: MemWrite=%b Address=%h WD=%h, required 1/3/33", MemWrite, Address, WD);
        end
        @(negedge clk);
        n_cmp++; if (ack0 !== 1'b1) begin n_fail++; $display("FAIL chg_ack: ack0=%b, required 1", ack0); end
        @(posedge clk); #1;
        req0 = 1'b0;
        drive_txn(1'b0, 1'b0, 32'd3, 32'h0, lat, mr, mw, ad, wd);
        drive_txn(1'b0, 1'b0, 32'd7, 32'h0, lat, mr, mw, ad, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_reset_mid_read();
        test_simultaneous();
        test_fairness();
        test_out_of_range();
        test_field_change();
        repeat (4) @(posedge clk);
        n_cmp++;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d/%0d expected acks outstanding, required 0/0", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
